// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin sharing of one bank of gate-level D latches
// between NREQ requesters. Produces a registered, glitch-free latch enable with
// cycle-counted setup / pulse / hold windows, and drives the latch reset pins
// for a clear request (which outranks all writes).
module latch_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int SETUP = 1,
   parameter int PULSE = 2,
   parameter int HOLD  = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*WIDTH-1:0] i_wdata,
   input  logic                  i_clr,
   output logic [NREQ-1:0]       o_grant,
   output logic [NREQ-1:0]       o_done,
   output logic                  o_clr_done,
   output logic [WIDTH-1:0]      o_latch_data,
   output logic                  o_latch_en,
   output logic                  o_latch_rst,
   output logic                  o_busy
);

   // Counter must hold the longest phase length minus one.
   localparam int MAXPH = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                          : ((PULSE > HOLD) ? PULSE : HOLD);
   localparam int CW = (MAXPH < 2) ? 1 : $clog2(MAXPH);
   localparam int PW = (NREQ < 2) ? 1 : $clog2(NREQ);

   localparam logic [CW-1:0] C_SETUP = CW'(SETUP - 1);
   localparam logic [CW-1:0] C_PULSE = CW'(PULSE - 1);
   localparam logic [CW-1:0] C_HOLD  = CW'(HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE, S_CLR, S_CLR_DONE
   } state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_ptr;
   logic [NREQ-1:0]   r_grant;
   logic [NREQ-1:0]   r_done;
   logic              r_clr_done;
   logic [WIDTH-1:0]  r_latch_data;
   logic              r_latch_en;
   logic              r_busy;

   logic              w_win_valid;
   logic [PW-1:0]     w_win_idx;
   logic [PW-1:0]     w_next_ptr;
   logic [NREQ-1:0]   w_win_onehot;
   logic [WIDTH-1:0]  w_win_data;

   // Round-robin search: first asserted request at or after r_ptr, wrapping.
   // Scanning from the far end lets the nearest candidate overwrite the rest.
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int v_idx;
         v_idx = (int'(r_ptr) + k) % NREQ;
         if (i_req[v_idx]) begin
            w_win_valid = 1'b1;
            w_win_idx   = PW'(v_idx);
         end
      end
   end

   assign w_win_onehot = NREQ'(1) << w_win_idx;
   assign w_next_ptr   = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
   assign w_win_data   = i_wdata[int'(w_win_idx)*WIDTH +: WIDTH];

   // Phase sequencer; arbitration happens in IDLE, DONE and CLR_DONE so that
   // transactions can follow each other with no idle gap.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_ptr        <= '0;
         r_grant      <= '0;
         r_done       <= '0;
         r_clr_done   <= 1'b0;
         r_latch_data <= '0;
         r_latch_en   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_done     <= '0;
         r_clr_done <= 1'b0;
         case (r_state)
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state    <= S_PULSE;
                  r_cnt      <= C_PULSE;
                  r_latch_en <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_PULSE: begin
               if (r_cnt == '0) begin
                  r_state    <= S_HOLD;
                  r_cnt      <= C_HOLD;
                  r_latch_en <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_done  <= r_grant;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_CLR: begin
               if (r_cnt == '0) begin
                  r_state    <= S_CLR_DONE;
                  r_clr_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               // S_IDLE, S_DONE, S_CLR_DONE: pick the next owner.
               if (i_clr) begin
                  r_state <= S_CLR;
                  r_cnt   <= C_PULSE;
                  r_grant <= '0;
                  r_busy  <= 1'b1;
               end else if (w_win_valid) begin
                  r_state      <= S_SETUP;
                  r_cnt        <= C_SETUP;
                  r_grant      <= w_win_onehot;
                  r_latch_data <= w_win_data;
                  r_ptr        <= w_next_ptr;
                  r_busy       <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Latch reset pins are held during the reset cycle as well as during a clear.
   assign o_latch_rst  = i_reset | (r_state == S_CLR);

   assign o_grant      = r_grant;
   assign o_done       = r_done;
   assign o_clr_done   = r_clr_done;
   assign o_latch_data = r_latch_data;
   assign o_latch_en   = r_latch_en;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: default-timing instance plus a second
// instance with SETUP=3, PULSE=1, HOLD=2. Cycle n means "after edge n-1",
// where edge 0 is the edge that samples the request.
module tb_latch_bank_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // default-parameter instance
   logic        rst, clr;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  grant, done;
   logic        clr_done, len, lrst, busy;
   logic [7:0]  ldata;

   // SETUP=3 PULSE=1 HOLD=2 instance
   logic        rst2, clr2;
   logic [3:0]  req2;
   logic [31:0] wdata2;
   logic [3:0]  grant2, done2;
   logic        clr_done2, len2, lrst2, busy2;
   logic [7:0]  ldata2;

   latch_bank_arbiter #(.NREQ(4), .WIDTH(8), .SETUP(1), .PULSE(2), .HOLD(1)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_req(req), .i_wdata(wdata), .i_clr(clr),
      .o_grant(grant), .o_done(done), .o_clr_done(clr_done), .o_latch_data(ldata),
      .o_latch_en(len), .o_latch_rst(lrst), .o_busy(busy));

   latch_bank_arbiter #(.NREQ(4), .WIDTH(8), .SETUP(3), .PULSE(1), .HOLD(2)) u_dut2 (
      .i_clock(clk), .i_reset(rst2), .i_req(req2), .i_wdata(wdata2), .i_clr(clr2),
      .o_grant(grant2), .o_done(done2), .o_clr_done(clr_done2), .o_latch_data(ldata2),
      .o_latch_en(len2), .o_latch_rst(lrst2), .o_busy(busy2));

   // status vector: {grant, done, clr_done, latch_en, latch_rst, busy}
   logic [11:0] obs, exp_v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'hF; clr = 1'b1; wdata = 32'hFFFF_FFFF;
      tick();
      obs   = {grant, done, clr_done, len, lrst, busy};
      exp_v = {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_outputs got %h expected %h", obs, exp_v);
      end
      checks++;
      if (ldata !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h expected 00", ldata);
      end
      rst = 1'b0; req = '0; clr = 1'b0;
      tick(); tick();
      obs   = {grant, done, clr_done, len, lrst, busy};
      exp_v = 12'h000;
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL idle_outputs got %h expected %h", obs, exp_v);
      end
      $display("txn reset: done");
   endtask

   task automatic test_single();
      logic [3:0] eg, ed;
      do_reset();
      wdata = 32'h3322_11A5; req = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         tick();
         eg    = (c <= 5) ? 4'b0001 : 4'b0000;
         ed    = (c == 5) ? 4'b0001 : 4'b0000;
         obs   = {grant, done, clr_done, len, lrst, busy};
         exp_v = {eg, ed, 1'b0, (c == 2 || c == 3), 1'b0, (c <= 5)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL single_c%0d got %h expected %h", c, obs, exp_v);
         end
         if (c <= 5) begin
            checks++;
            if (ldata !== 8'hA5) begin
               errors++;
               $display("FAIL single_data_c%0d got %h expected a5", c, ldata);
            end
         end
         if (c == 5) req = 4'b0000;
      end
      $display("txn single: req0 data a5");
   endtask

   task automatic test_round_robin();
      logic [3:0] eg, ed;
      logic [7:0] eb;
      int k, ph;
      do_reset();
      wdata = 32'h4433_2211; req = 4'hF;
      for (int c = 1; c <= 26; c++) begin
         tick();
         k  = (c - 1) / 5;
         ph = (c - 1) % 5;
         if (c <= 25) begin
            eg    = 4'b0001 << (k % 4);
            ed    = (ph == 4) ? eg : 4'b0000;
            obs   = {grant, done, clr_done, len, lrst, busy};
            exp_v = {eg, ed, 1'b0, (ph == 1 || ph == 2), 1'b0, 1'b1};
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL rr_c%0d got %h expected %h", c, obs, exp_v);
            end
            if (ph == 0) begin
               eb = 8'h11 * 8'((k % 4) + 1);
               checks++;
               if (ldata !== eb) begin
                  errors++;
                  $display("FAIL rr_data_c%0d got %h expected %h", c, ldata, eb);
               end
               $display("txn rr: grant %b", grant);
            end
         end else begin
            checks++;
            if ({grant, busy} !== 5'b0) begin
               errors++;
               $display("FAIL rr_idle got %b expected 00000", {grant, busy});
            end
         end
         if (c == 25) req = 4'b0000;
      end
   endtask

   task automatic test_clr_priority();
      logic [3:0] eg, ed;
      do_reset();
      wdata = 32'h005A_0000; clr = 1'b1; req = 4'b0100;
      for (int c = 1; c <= 9; c++) begin
         tick();
         eg    = (c >= 4 && c <= 8) ? 4'b0100 : 4'b0000;
         ed    = (c == 8) ? 4'b0100 : 4'b0000;
         obs   = {grant, done, clr_done, len, lrst, busy};
         exp_v = {eg, ed, (c == 3), (c == 5 || c == 6), (c <= 2), (c <= 8)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL clr_c%0d got %h expected %h", c, obs, exp_v);
         end
         if (c == 4) begin
            checks++;
            if (ldata !== 8'h5A) begin
               errors++;
               $display("FAIL clr_data got %h expected 5a", ldata);
            end
         end
         if (c == 3) clr = 1'b0;
         if (c == 8) req = 4'b0000;
      end
      $display("txn clr then req2");
   endtask

   task automatic test_req_drop();
      logic [3:0] eg, ed;
      do_reset();
      wdata = 32'h003C_0000; req = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         tick();
         eg    = (c <= 5) ? 4'b0100 : 4'b0000;
         ed    = (c == 5) ? 4'b0100 : 4'b0000;
         obs   = {grant, done, clr_done, len, lrst, busy};
         exp_v = {eg, ed, 1'b0, (c == 2 || c == 3), 1'b0, (c <= 5)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL drop_c%0d got %h expected %h", c, obs, exp_v);
         end
         if (c >= 2 && c <= 5) begin
            checks++;
            if (ldata !== 8'h3C) begin
               errors++;
               $display("FAIL drop_data_c%0d got %h expected 3c", c, ldata);
            end
         end
         if (c == 2) begin
            req = 4'b0000; wdata = 32'hFFFF_FFFF;
         end
      end
      $display("txn req2 dropped mid-pulse");
   endtask

   task automatic test_reset_mid();
      do_reset();
      wdata = 32'h7700_0011; req = 4'b0001;
      tick();                          // cycle 1, pointer advances to 1
      req = 4'b1001;
      tick();                          // cycle 2, in PULSE
      checks++;
      if (len !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pulse got %b expected 1", len);
      end
      rst = 1'b1;
      tick();
      obs   = {grant, done, clr_done, len, lrst, busy};
      exp_v = {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v || ldata !== 8'h00) begin
         errors++;
         $display("FAIL rmid_abort got %h/%h expected %h/00", obs, ldata, exp_v);
      end
      rst = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if (grant !== 4'b0001 || done !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL rmid_regrant_c%0d got %b/%b expected 0001/%b",
                     c, grant, done, (c == 5) ? 4'b0001 : 4'b0000);
         end
         if (c == 5) req = 4'b0000;
      end
      checks++;
      if (ldata !== 8'h11) begin
         errors++;
         $display("FAIL rmid_data got %h expected 11", ldata);
      end
      tick();
      $display("txn reset mid-transaction, regrant req0");
   endtask

   task automatic test_params();
      logic [3:0] eg, ed;
      rst2 = 1'b1; req2 = '0; clr2 = 1'b0; wdata2 = 32'h0000_C300;
      tick();
      rst2 = 1'b0; req2 = 4'b0010;
      for (int c = 1; c <= 8; c++) begin
         tick();
         eg    = (c <= 7) ? 4'b0010 : 4'b0000;
         ed    = (c == 7) ? 4'b0010 : 4'b0000;
         obs   = {grant2, done2, clr_done2, len2, lrst2, busy2};
         exp_v = {eg, ed, 1'b0, (c == 4), 1'b0, (c <= 7)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL params_c%0d got %h expected %h", c, obs, exp_v);
         end
         if (c == 1) begin
            checks++;
            if (ldata2 !== 8'hC3) begin
               errors++;
               $display("FAIL params_data got %h expected c3", ldata2);
            end
         end
         if (c == 7) req2 = 4'b0000;
      end
      $display("txn params 3/1/2 req1");
   endtask

   initial begin
      rst = 1'b1; req = '0; clr = 1'b0; wdata = '0;
      rst2 = 1'b1; req2 = '0; clr2 = 1'b0; wdata2 = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_clr_priority();
      test_req_drop();
      test_reset_mid();
      test_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
